// File: rtl/vga_pkg.sv
// Display geometry, word layout and arbiter state encoding shared by the
// VRAM scan-out path.
package vga_pkg;

   localparam int PIX_W   = 8;
   localparam int WORD_W  = 2 * PIX_W;
   localparam int HACTIVE = 480;
   localparam int VACTIVE = 272;
   localparam int ADDR_W  = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry word FIFO between the VRAM read port and the pixel serialiser.
// Flush is synchronous and overrides a push or pop in the same cycle.
module pix_fifo2
   import vga_pkg::*;
#(
   parameter int W = WORD_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         empty
);

   logic [W-1:0] slot [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign empty   = (count == 2'd0);
   assign head    = slot[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) slot[wr_ptr] <= din;
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display prefetch (two words ahead) has absolute
// priority, the pixel writer takes every remaining cycle.
module vram_arbiter #(
   parameter int PIX_W   = vga_pkg::PIX_W,
   parameter int HACTIVE = vga_pkg::HACTIVE,
   parameter int VACTIVE = vga_pkg::VACTIVE,
   parameter int ADDR_W  = vga_pkg::ADDR_W
) (
   input  logic                 pxclk_i,
   input  logic                 rstn_i,
   input  logic                 frame_start_i,
   input  logic                 de_i,
   output logic [PIX_W-1:0]     pix_o,
   output logic                 pix_valid_o,
   output logic                 underrun_o,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [ADDR_W-1:0]    wr_addr_i,
   input  logic [2*PIX_W-1:0]   wr_data_i,
   output logic                 mem_en_o,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [2*PIX_W-1:0]   mem_wdata_o,
   input  logic [2*PIX_W-1:0]   mem_rdata_i
);

   localparam int                LINE_WORDS  = HACTIVE / 2;
   localparam int                POP_W       = $clog2(LINE_WORDS + 1);
   localparam int                LINE_W      = $clog2(VACTIVE + 1);
   localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(LINE_WORDS * VACTIVE);

   vga_pkg::arb_state_t state, state_next;

   logic [ADDR_W-1:0]  disp_addr;
   logic [POP_W-1:0]   pop_cnt;
   logic [LINE_W-1:0]  line_cnt;
   logic               rd_pending;
   logic               de_d;
   logic               phase;
   logic [2*PIX_W-1:0] fifo_head;
   logic [1:0]         fifo_count;
   logic               fifo_empty;
   logic [2:0]         occ_sum;
   logic               fetch_now;
   logic               cur_phase;
   logic               consume;
   logic               pop;
   logic               underrun_hit;
   logic               line_done;
   logic [PIX_W-1:0]   pix_next;

   pix_fifo2 #(.W(2 * PIX_W)) u_fifo (
      .clk   (pxclk_i),
      .rst_n (rstn_i),
      .flush (frame_start_i),
      .push  (rd_pending),
      .pop   (pop),
      .din   (mem_rdata_i),
      .head  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   always_comb begin
      occ_sum      = {1'b0, fifo_count} + {2'b00, rd_pending};
      fetch_now    = (state == vga_pkg::S_RUN) && (occ_sum < 3'd2) && (disp_addr < FRAME_WORDS);
      cur_phase    = (de_i && !de_d) ? 1'b0 : phase;
      consume      = de_i && !frame_start_i;
      pop          = consume && cur_phase && !fifo_empty;
      underrun_hit = consume && fifo_empty;
      line_done    = pop && (pop_cnt == POP_W'(LINE_WORDS - 1));

      pix_next = '0;
      if (consume && !fifo_empty)
         pix_next = cur_phase ? fifo_head[2*PIX_W-1:PIX_W] : fifo_head[PIX_W-1:0];

      wr_ready_o  = !fetch_now;
      mem_en_o    = fetch_now || (wr_valid_i && wr_ready_o);
      mem_we_o    = !fetch_now && wr_valid_i;
      mem_addr_o  = fetch_now ? disp_addr : wr_addr_i;
      mem_wdata_o = fetch_now ? '0 : wr_data_i;

      state_next = state;
      if (frame_start_i)
         state_next = vga_pkg::S_RUN;
      else if ((state == vga_pkg::S_RUN) && line_done && (line_cnt == LINE_W'(VACTIVE - 1)))
         state_next = vga_pkg::S_HOLD;
   end

   // A fetch issued in the frame_start cycle is never marked pending, so its data is dropped.
   always_ff @(posedge pxclk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= vga_pkg::S_IDLE;
         disp_addr   <= '0;
         pop_cnt     <= '0;
         line_cnt    <= '0;
         rd_pending  <= 1'b0;
         de_d        <= 1'b0;
         phase       <= 1'b0;
         pix_o       <= '0;
         pix_valid_o <= 1'b0;
         underrun_o  <= 1'b0;
      end else begin
         state       <= state_next;
         de_d        <= de_i;
         pix_valid_o <= de_i;
         pix_o       <= pix_next;
         rd_pending  <= fetch_now && !frame_start_i;
         if (de_i) phase <= ~cur_phase;
         if (frame_start_i) begin
            disp_addr  <= '0;
            pop_cnt    <= '0;
            line_cnt   <= '0;
            underrun_o <= 1'b0;
         end else begin
            if (fetch_now) disp_addr <= disp_addr + ADDR_W'(1);
            if (line_done) begin
               pop_cnt  <= '0;
               line_cnt <= line_cnt + LINE_W'(1);
            end else if (pop) begin
               pop_cnt <= pop_cnt + POP_W'(1);
            end
            if (underrun_hit) underrun_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read VRAM model whose word n
// holds pixels 2n and 2n+1, so a linear scan yields pixel k = k mod 256.
module tb_vram_arbiter;

   localparam int HACT       = 480;
   localparam int VACT       = 4;
   localparam int LINE_WORDS = HACT / 2;

   logic        pxclk = 1'b0;
   logic        rstn = 1'b0;
   logic        frame_start = 1'b0;
   logic        de = 1'b0;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic [7:0]  pix;
   logic        pix_valid, underrun, wr_ready, mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;

   logic [15:0] mem [65536];
   bit          written [65536];

   int unsigned rd_total = 0, wr_acc_total = 0, wr_mem_total = 0, conflict_total = 0;
   logic [15:0] last_rd_addr = '0;
   int unsigned frame_rd_base = 0;
   int          vec_cnt = 0;
   int          miss_cnt = 0;

   vram_arbiter #(.PIX_W(8), .HACTIVE(HACT), .VACTIVE(VACT), .ADDR_W(16)) dut (
      .pxclk_i       (pxclk),
      .rstn_i        (rstn),
      .frame_start_i (frame_start),
      .de_i          (de),
      .pix_o         (pix),
      .pix_valid_o   (pix_valid),
      .underrun_o    (underrun),
      .wr_valid_i    (wr_valid),
      .wr_ready_o    (wr_ready),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .mem_en_o      (mem_en),
      .mem_we_o      (mem_we),
      .mem_addr_o    (mem_addr),
      .mem_wdata_o   (mem_wdata),
      .mem_rdata_i   (mem_rdata)
   );

   always #5 pxclk = ~pxclk;

   function automatic logic [15:0] init_word(input logic [15:0] a);
      logic [7:0] lo;
      lo = {a[6:0], 1'b0};
      return {lo + 8'd1, lo};
   endfunction

   always @(posedge pxclk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
         end
      end
   end

   always @(negedge pxclk) begin
      if (mem_en && !mem_we) begin
         rd_total     <= rd_total + 1;
         last_rd_addr <= mem_addr;
      end
      if (mem_en && mem_we)   wr_mem_total <= wr_mem_total + 1;
      if (wr_valid && wr_ready) wr_acc_total <= wr_acc_total + 1;
      if (mem_en && !mem_we && wr_valid && wr_ready) conflict_total <= conflict_total + 1;
   end

   task automatic step();
      @(posedge pxclk);
      #1;
   endtask

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      int unsigned r0;
      rstn = 1'b0;
      #3;
      vec_cnt++;
      if ({pix, pix_valid, underrun, wr_ready, mem_en, mem_we} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         miss_cnt++;
         $display("[TB] FAIL reset_outputs: got %b, expected %b", {pix, pix_valid, underrun, wr_ready, mem_en, mem_we},
                  {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
      vec_cnt++;
      if ({mem_addr, mem_wdata} !== 32'h0) begin
         miss_cnt++;
         $display("[TB] FAIL reset_mem_bus: got %h, expected 0", {mem_addr, mem_wdata});
      end
      repeat (3) step();
      rstn = 1'b1;
      r0 = rd_total;
      repeat (6) step();
      vec_cnt++;
      if (rd_total != r0) begin
         miss_cnt++;
         $display("[TB] FAIL idle_no_fetch: got %0d reads, expected 0", rd_total - r0);
      end
   endtask

   task automatic test_basic_scan();
      frame_rd_base = rd_total;
      pulse_frame_start();
      repeat (4) step();
      for (int k = 0; k < HACT; k++) begin
         de = 1'b1;
         step();
         vec_cnt++;
         if (pix !== 8'(k) || pix_valid !== 1'b1) begin
            miss_cnt++;
            $display("[TB] FAIL scan_pix[%0d]: got %0d valid %b, expected %0d valid 1", k, pix, pix_valid, 8'(k));
         end
      end
      de = 1'b0;
      vec_cnt++;
      if (underrun !== 1'b0) begin
         miss_cnt++;
         $display("[TB] FAIL scan_underrun: got %b, expected 0", underrun);
      end
      repeat (6) step();
   endtask

   task automatic test_contended_writer();
      int unsigned rd0, wa0, wm0, c0;
      rd0 = rd_total; wa0 = wr_acc_total; wm0 = wr_mem_total; c0 = conflict_total;
      wr_valid = 1'b1;
      for (int k = 0; k < HACT; k++) begin
         de      = 1'b1;
         wr_addr = 16'h8000 + 16'(k);
         wr_data = {8'hA5, 8'(k)};
         step();
         vec_cnt++;
         if (pix !== 8'(HACT + k)) begin
            miss_cnt++;
            $display("[TB] FAIL contended_pix[%0d]: got %0d, expected %0d", k, pix, 8'(HACT + k));
         end
      end
      de = 1'b0;
      step();
      vec_cnt++;
      if (rd_total - rd0 != LINE_WORDS) begin
         miss_cnt++;
         $display("[TB] FAIL contended_reads: got %0d, expected %0d", rd_total - rd0, LINE_WORDS);
      end
      vec_cnt++;
      if (wr_acc_total - wa0 != 241) begin
         miss_cnt++;
         $display("[TB] FAIL contended_writes: got %0d, expected 241", wr_acc_total - wa0);
      end
      vec_cnt++;
      if (wr_mem_total - wm0 != wr_acc_total - wa0) begin
         miss_cnt++;
         $display("[TB] FAIL write_cycles: got %0d, expected %0d", wr_mem_total - wm0, wr_acc_total - wa0);
      end
      vec_cnt++;
      if (conflict_total != c0) begin
         miss_cnt++;
         $display("[TB] FAIL read_write_overlap: got %0d, expected 0", conflict_total - c0);
      end
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      vec_cnt++;
      if (!written[16'h8001] || mem[16'h8001] !== 16'hA501) begin
         miss_cnt++;
         $display("[TB] FAIL write_granted_data: got %h, expected a501", mem[16'h8001]);
      end
      vec_cnt++;
      if (written[16'h8002]) begin
         miss_cnt++;
         $display("[TB] FAIL write_during_fetch: got 1, expected 0");
      end
      repeat (6) step();
   endtask

   task automatic test_frame_end();
      int unsigned r0;
      for (int l = 2; l < VACT; l++) begin
         for (int k = 0; k < HACT; k++) begin
            de = 1'b1;
            step();
            vec_cnt++;
            if (pix !== 8'(l * HACT + k)) begin
               miss_cnt++;
               $display("[TB] FAIL frame_pix[%0d][%0d]: got %0d, expected %0d", l, k, pix, 8'(l * HACT + k));
            end
         end
         de = 1'b0;
         repeat (6) step();
      end
      vec_cnt++;
      if (last_rd_addr !== 16'(LINE_WORDS * VACT - 1)) begin
         miss_cnt++;
         $display("[TB] FAIL last_fetch_addr: got %h, expected %h", last_rd_addr, 16'(LINE_WORDS * VACT - 1));
      end
      vec_cnt++;
      if (rd_total - frame_rd_base != LINE_WORDS * VACT) begin
         miss_cnt++;
         $display("[TB] FAIL frame_reads: got %0d, expected %0d", rd_total - frame_rd_base, LINE_WORDS * VACT);
      end
      r0 = rd_total;
      repeat (20) step();
      vec_cnt++;
      if (rd_total != r0) begin
         miss_cnt++;
         $display("[TB] FAIL hold_no_fetch: got %0d reads, expected 0", rd_total - r0);
      end
   endtask

   task automatic test_underrun();
      pulse_frame_start();
      de = 1'b1;
      step();
      vec_cnt++;
      if (pix !== 8'd0 || underrun !== 1'b1) begin
         miss_cnt++;
         $display("[TB] FAIL underrun_hit: got pix %0d flag %b, expected pix 0 flag 1", pix, underrun);
      end
      repeat (5) step();
      vec_cnt++;
      if (pix !== 8'd3) begin
         miss_cnt++;
         $display("[TB] FAIL underrun_no_pop: got %0d, expected 3", pix);
      end
      de = 1'b0;
      repeat (10) step();
      vec_cnt++;
      if (underrun !== 1'b1) begin
         miss_cnt++;
         $display("[TB] FAIL underrun_sticky: got %b, expected 1", underrun);
      end
      pulse_frame_start();
      vec_cnt++;
      if (underrun !== 1'b0) begin
         miss_cnt++;
         $display("[TB] FAIL underrun_clear: got %b, expected 0", underrun);
      end
      repeat (6) step();
   endtask

   task automatic test_resync();
      pulse_frame_start();
      repeat (4) step();
      for (int k = 0; k < 100; k++) begin
         de = 1'b1;
         step();
         vec_cnt++;
         if (pix !== 8'(k)) begin
            miss_cnt++;
            $display("[TB] FAIL resync_pre_pix[%0d]: got %0d, expected %0d", k, pix, 8'(k));
         end
      end
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      de = 1'b0;
      vec_cnt++;
      if (pix !== 8'd0 || pix_valid !== 1'b1) begin
         miss_cnt++;
         $display("[TB] FAIL resync_pix_ignored: got %0d valid %b, expected 0 valid 1", pix, pix_valid);
      end
      @(negedge pxclk);
      vec_cnt++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0000}) begin
         miss_cnt++;
         $display("[TB] FAIL resync_first_fetch: got en %b we %b addr %h, expected en 1 we 0 addr 0000",
                  mem_en, mem_we, mem_addr);
      end
      @(posedge pxclk);
      #1;
      repeat (3) step();
      for (int k = 0; k < 4; k++) begin
         de = 1'b1;
         step();
         vec_cnt++;
         if (pix !== 8'(k)) begin
            miss_cnt++;
            $display("[TB] FAIL resync_post_pix[%0d]: got %0d, expected %0d", k, pix, 8'(k));
         end
      end
      de = 1'b0;
      repeat (6) step();
   endtask

   task automatic test_reset_mid_line();
      int unsigned r0;
      pulse_frame_start();
      repeat (4) step();
      for (int k = 0; k < 50; k++) begin
         de = 1'b1;
         step();
      end
      #2;
      rstn = 1'b0;
      #1;
      vec_cnt++;
      if ({pix, pix_valid, underrun, wr_ready, mem_en, mem_we} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         miss_cnt++;
         $display("[TB] FAIL midline_reset_outputs: got %b, expected %b", {pix, pix_valid, underrun, wr_ready, mem_en, mem_we},
                  {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
      repeat (3) step();
      de   = 1'b0;
      rstn = 1'b1;
      r0   = rd_total;
      repeat (10) step();
      vec_cnt++;
      if (rd_total != r0 || pix !== 8'd0) begin
         miss_cnt++;
         $display("[TB] FAIL post_reset_quiet: got %0d reads pix %0d, expected 0 reads pix 0", rd_total - r0, pix);
      end
      pulse_frame_start();
      repeat (4) step();
      for (int k = 0; k < 4; k++) begin
         de = 1'b1;
         step();
         vec_cnt++;
         if (pix !== 8'(k)) begin
            miss_cnt++;
            $display("[TB] FAIL resume_pix[%0d]: got %0d, expected %0d", k, pix, 8'(k));
         end
      end
      de = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_contended_writer();
      test_frame_end();
      test_underrun();
      test_resync();
      test_reset_mid_line();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
